// File: rtl/control_pkg.sv
`timescale 1ns/100ps
// Shared definitions for the control_cmd block: FSM encoding, widths and the
// init-counter load helper.
package control_pkg;

    localparam int CTRL_WIDTH = 32;
    localparam int INIT_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // INIT is left when the counter reads zero, so it is loaded with cycles-1.
    function automatic logic [INIT_CNT_W-1:0] init_load(input int cycles);
        return INIT_CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/control_counter.sv
`timescale 1ns/100ps
// WIDTH-bit enabled incrementer with registered valid strobe and wrap pulse.
// Asynchronous active-low clear.
module control_counter
    import control_pkg::*;
#(
    parameter int WIDTH = CTRL_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             valid,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            valid <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            // valid/wrap describe the increment taken on this edge, so wrap implies valid.
            valid <= enable;
            wrap  <= enable && (count == '1);
            if (enable) begin
                count <= count + ONE;
            end
        end
    end

endmodule

// File: rtl/control_cmd.sv
`timescale 1ns/100ps
// Control block: sticky out-of-reset flag, fixed INIT delay, then a gated
// free-running data counter with valid strobe and wrap pulse.
module control_cmd
    import control_pkg::*;
#(
    parameter int WIDTH       = CTRL_WIDTH,
    parameter int INIT_CYCLES = 4
) (
    input  logic             iClock,
    input  logic             iReset_n,
    input  logic             iEnable,
    output logic             oPaseePorReset,
    output logic [WIDTH-1:0] oData,
    output logic             oValid,
    output logic             oWrap,
    output logic [1:0]       oState
);

    localparam logic [INIT_CNT_W-1:0] INIT_LOAD = init_load(INIT_CYCLES);
    localparam logic [INIT_CNT_W-1:0] CNT_ONE   = INIT_CNT_W'(1);

    state_t                state;
    logic [INIT_CNT_W-1:0] init_cnt;
    logic                  run_en;

    // Increments only on an edge seen in RUN, so the HOLD->RUN edge is a bubble.
    assign run_en = (state == ST_RUN) && iEnable;
    assign oState = state;

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state          <= ST_IDLE;
            init_cnt       <= '0;
            oPaseePorReset <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state          <= ST_INIT;
                    oPaseePorReset <= 1'b1;
                    init_cnt       <= INIT_LOAD;
                end
                ST_INIT: begin
                    if (init_cnt == '0) begin
                        state <= ST_RUN;
                    end else begin
                        init_cnt <= init_cnt - CNT_ONE;
                    end
                end
                ST_RUN: begin
                    if (!iEnable) begin
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (iEnable) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    control_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk    (iClock),
        .rst_n  (iReset_n),
        .enable (run_en),
        .count  (oData),
        .valid  (oValid),
        .wrap   (oWrap)
    );

endmodule

// File: tb/tb_control_cmd.sv
`timescale 1ns/100ps
// Directed bench for control_cmd: reset, INIT timing, run/hold bubble, async
// reset mid-run, a 4-bit wrap instance and a one-cycle INIT instance.
module tb_control_cmd;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        en_w4;
    logic        en_i1;

    logic        flag, valid, wrap;
    logic [31:0] data;
    logic [1:0]  st;

    logic        w4_flag, w4_valid, w4_wrap;
    logic [3:0]  w4_data;
    logic [1:0]  w4_st;

    logic        i1_flag, i1_valid, i1_wrap;
    logic [31:0] i1_data;
    logic [1:0]  i1_st;

    int n_cmp = 0;
    int n_err = 0;

    always #1 clk = ~clk;

    control_cmd #(.WIDTH(32), .INIT_CYCLES(4)) u_dut (
        .iClock(clk), .iReset_n(rst_n), .iEnable(en),
        .oPaseePorReset(flag), .oData(data), .oValid(valid), .oWrap(wrap), .oState(st)
    );

    control_cmd #(.WIDTH(4), .INIT_CYCLES(4)) u_w4 (
        .iClock(clk), .iReset_n(rst_n), .iEnable(en_w4),
        .oPaseePorReset(w4_flag), .oData(w4_data), .oValid(w4_valid), .oWrap(w4_wrap), .oState(w4_st)
    );

    control_cmd #(.WIDTH(32), .INIT_CYCLES(1)) u_i1 (
        .iClock(clk), .iReset_n(rst_n), .iEnable(en_i1),
        .oPaseePorReset(i1_flag), .oData(i1_data), .oValid(i1_valid), .oWrap(i1_wrap), .oState(i1_st)
    );

    typedef struct {
        logic        en;
        logic        en_i1;
        logic [1:0]  st;
        logic [31:0] data;
        logic        valid;
        logic        flag;
        logic [1:0]  i1_st;
        logic [31:0] i1_data;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic e, input logic e1, input logic [1:0] s, input logic [31:0] d,
                           input logic v, input logic f, input logic [1:0] s1, input logic [31:0] d1);
        vec_t x;
        x.en = e; x.en_i1 = e1; x.st = s; x.data = d; x.valid = v; x.flag = f;
        x.i1_st = s1; x.i1_data = d1;
        vecs.push_back(x);
    endtask

    // Entered at a falling edge; each vector covers one rising edge.
    task automatic run_vecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            en    = vecs[i].en;
            en_i1 = vecs[i].en_i1;
            @(negedge clk);
            chk($sformatf("%s[%0d].state", tag, i), {30'd0, st}, {30'd0, vecs[i].st});
            chk($sformatf("%s[%0d].data", tag, i), data, vecs[i].data);
            chk($sformatf("%s[%0d].valid", tag, i), {31'd0, valid}, {31'd0, vecs[i].valid});
            chk($sformatf("%s[%0d].wrap", tag, i), {31'd0, wrap}, 32'd0);
            chk($sformatf("%s[%0d].flag", tag, i), {31'd0, flag}, {31'd0, vecs[i].flag});
            chk($sformatf("%s[%0d].i1_state", tag, i), {30'd0, i1_st}, {30'd0, vecs[i].i1_st});
            chk($sformatf("%s[%0d].i1_data", tag, i), i1_data, vecs[i].i1_data);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".flag"},  {31'd0, flag},  32'd0);
        chk({tag, ".data"},  data,           32'd0);
        chk({tag, ".valid"}, {31'd0, valid}, 32'd0);
        chk({tag, ".wrap"},  {31'd0, wrap},  32'd0);
        chk({tag, ".state"}, {30'd0, st},    32'd0);
        chk({tag, ".w4_state"}, {30'd0, w4_st}, 32'd0);
        chk({tag, ".i1_state"}, {30'd0, i1_st}, 32'd0);
        chk({tag, ".i1_flag"},  {31'd0, i1_flag}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        en_w4 = 1'b0;
        en_i1 = 1'b0;

        // Reset held for 50 ns; outputs stay cleared throughout.
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            chk_all_zero($sformatf("rst_hold[%0d]", k));
        end
        rst_n = 1'b1;

        // First release: INIT x4, count to 10, hold 3, bubble, count to 0x20.
        vecs.delete();
        add_vec(1, 0, 2'd1, 0, 0, 1, 2'd1, 0);
        add_vec(1, 0, 2'd1, 0, 0, 1, 2'd2, 0);
        add_vec(1, 0, 2'd1, 0, 0, 1, 2'd3, 0);
        add_vec(1, 0, 2'd1, 0, 0, 1, 2'd3, 0);
        add_vec(1, 0, 2'd2, 0, 0, 1, 2'd3, 0);
        for (int n = 1; n <= 10; n++) add_vec(1, 0, 2'd2, n, 1, 1, 2'd3, 0);
        for (int n = 0; n < 3; n++)   add_vec(0, 0, 2'd3, 10, 0, 1, 2'd3, 0);
        add_vec(1, 0, 2'd2, 10, 0, 1, 2'd3, 0);
        for (int n = 11; n <= 32; n++) add_vec(1, 0, 2'd2, n, 1, 1, 2'd3, 0);
        run_vecs("run_a");

        // Asynchronous reset in the low phase while oData=0x20.
        #0.3 rst_n = 1'b0;
        #0.2 chk_all_zero("async_rst");
        repeat (3) @(negedge clk);
        chk_all_zero("rst_again");
        rst_n = 1'b1;

        // Second release: INIT repeats; one-cycle INIT instance ignores enable toggles.
        vecs.delete();
        add_vec(1, 0, 2'd1, 0, 0, 1, 2'd1, 0);
        add_vec(1, 1, 2'd1, 0, 0, 1, 2'd2, 0);
        add_vec(1, 0, 2'd1, 0, 0, 1, 2'd3, 0);
        add_vec(1, 1, 2'd1, 0, 0, 1, 2'd2, 0);
        add_vec(1, 1, 2'd2, 0, 0, 1, 2'd2, 1);
        add_vec(1, 0, 2'd2, 1, 1, 1, 2'd3, 1);
        add_vec(1, 1, 2'd2, 2, 1, 1, 2'd2, 1);
        run_vecs("run_b");

        // 4-bit instance: parked in HOLD, then restart bubble and a full wrap.
        chk("w4.hold_state", {30'd0, w4_st}, 32'd3);
        chk("w4.hold_data", {28'd0, w4_data}, 32'd0);
        chk("w4.flag", {31'd0, w4_flag}, 32'd1);
        en_w4 = 1'b1;
        @(negedge clk);
        chk("w4.bubble_state", {30'd0, w4_st}, 32'd2);
        chk("w4.bubble_data", {28'd0, w4_data}, 32'd0);
        chk("w4.bubble_valid", {31'd0, w4_valid}, 32'd0);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            chk($sformatf("w4[%0d].data", k), {28'd0, w4_data}, 32'(k % 16));
            chk($sformatf("w4[%0d].valid", k), {31'd0, w4_valid}, 32'd1);
            chk($sformatf("w4[%0d].wrap", k), {31'd0, w4_wrap}, (k == 16) ? 32'd1 : 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/control_cmd.md
Name: control_cmd

Overview:
DUT-side control block for proyecto1. It is driven by the command tester's clock/reset stimulus and produces the signals the tester samples.
- After reset release it raises a sticky "passed through reset" flag.
- It then waits a fixed init period and runs a WIDTH-bit free-running data counter, gated by an enable.
- The counter output carries a valid strobe and a wrap pulse.

Parameters:
- WIDTH, 32, width of the oData counter.
- INIT_CYCLES, 4, cycles spent in INIT after reset release; legal range 1..255.

Ports:
- iClock  input  1  single system clock, rising edge.
- iReset_n  input  1  asynchronous, active-low reset.
- iEnable  input  1  run/hold request, sampled on the rising edge of iClock.
- oPaseePorReset  output  1  sticky flag: block has left reset.
- oData  output  WIDTH  counter value, registered.
- oValid  output  1  high the cycle after oData changed by an increment.
- oWrap  output  1  one-cycle pulse when oData wraps from all-ones to 0.
- oState  output  2  current FSM state, for debug and the bench.

Behaviour:
Clock and reset:
- One clock; reset is asynchronous and active-low.
- iReset_n=0 immediately forces: state=IDLE, init counter=0, oPaseePorReset=0, oData=0, oValid=0, oWrap=0.
- Release is sampled at the first rising edge with iReset_n=1.
- Reset asserted mid-operation (any state) clears everything at once, without waiting for a clock edge. oPaseePorReset falls to 0 and sets again only after the next release.

FSM states, encoded in oState:
- IDLE=0: unconditionally at the first edge out of reset: go to INIT, set oPaseePorReset=1, load init counter = INIT_CYCLES-1.
- INIT=1:
  - each edge: if init counter==0 go to RUN, else decrement it;
  - INIT therefore lasts exactly INIT_CYCLES cycles;
  - iEnable is ignored; oData stays 0, oValid=0.
- RUN=2, each edge:
  - iEnable=1: oData<=oData+1 (mod 2^WIDTH); oValid<=1; oWrap<=1 only when old oData == all-ones.
  - iEnable=0: go to HOLD; oData holds; oValid<=0; oWrap<=0.
- HOLD=3:
  - oData holds; oValid=0; oWrap=0.
  - iEnable=1 at an edge goes to RUN with no increment (one-cycle restart bubble). The first increment occurs on the following edge if iEnable is still 1.
  - iEnable=0 stays in HOLD.

Output rules:
- oPaseePorReset never deasserts except through reset.
- oValid and oWrap are registered. oWrap implies oValid in the same cycle.
- Wrap: all-ones + 1 gives 0, with oWrap=1 and oValid=1 for that one cycle.
- The 0x0 reached after a wrap is a valid sample.

Decomposition:
- Shared package control_pkg holds:
  - state localparams ST_IDLE=2'd0, ST_INIT=2'd1, ST_RUN=2'd2, ST_HOLD=2'd3;
  - CTRL_WIDTH default 32;
  - the init counter width of 8 bits.
- One sub-module is natural: control_counter (WIDTH-bit enabled incrementer with wrap pulse, async active-low clear). The FSM in control_cmd drives its enable.

Test Plan:
1. Hold iReset_n=0 for 50 ns with a 2 ns clock period -> oPaseePorReset=0, oData=0, oValid=0, oWrap=0, oState=0 throughout.
2. Release reset with iEnable=1 -> oPaseePorReset=1 after the first edge; oState=1 for exactly 4 cycles; then oState=2. oData reads 1,2,3,... on consecutive cycles with oValid=1.
3. In RUN at oData=10, drop iEnable for 3 cycles, then raise it -> oData stays 10, oValid=0, oState=3. One bubble cycle follows in RUN with oData=10. Then oData=11 with oValid=1.
4. WIDTH=4 instance, iEnable=1 -> oData goes 14,15,0,1; oWrap=1 only in the cycle oData=0; oValid stays 1 throughout.
5. Assert iReset_n=0 asynchronously mid-cycle while oData=0x20 in RUN -> all outputs 0 and oState=0 before the next edge. After release, the INIT sequence repeats with 4 cycles.
6. INIT_CYCLES=1 with iEnable toggling during INIT -> INIT lasts 1 cycle, oData stays 0 in INIT, and the toggles have no effect.
